// File: rtl/bc_pkg.sv
// Shared state encoding and per-state control words for the bc_seq controller.
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        S1,
        S2,
        S3,
        S4,
        DONE
    } state_t;

    // Select fields hold the narrowest constants; the top zero-extends them to MSEL_W.
    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       lx;
        logic       ls;
        logic       lh;
        logic       h;
        logic       busy;
        logic       done;
    } ctrl_t;

    localparam ctrl_t CW_IDLE = '{m0: 2'd0, m1: 2'd0, m2: 2'd0, lx: 1'b0, ls: 1'b0,
                                  lh: 1'b0, h: 1'b0, busy: 1'b0, done: 1'b0};
    localparam ctrl_t CW_INIT = '{m0: 2'd0, m1: 2'd1, m2: 2'd0, lx: 1'b1, ls: 1'b0,
                                  lh: 1'b1, h: 1'b1, busy: 1'b1, done: 1'b0};
    localparam ctrl_t CW_S1   = '{m0: 2'd1, m1: 2'd0, m2: 2'd3, lx: 1'b0, ls: 1'b1,
                                  lh: 1'b0, h: 1'b1, busy: 1'b1, done: 1'b0};
    localparam ctrl_t CW_S2   = '{m0: 2'd2, m1: 2'd0, m2: 2'd0, lx: 1'b0, ls: 1'b0,
                                  lh: 1'b1, h: 1'b1, busy: 1'b1, done: 1'b0};
    localparam ctrl_t CW_S3   = '{m0: 2'd0, m1: 2'd2, m2: 2'd3, lx: 1'b0, ls: 1'b1,
                                  lh: 1'b0, h: 1'b0, busy: 1'b1, done: 1'b0};
    localparam ctrl_t CW_S4   = '{m0: 2'd3, m1: 2'd0, m2: 2'd2, lx: 1'b0, ls: 1'b1,
                                  lh: 1'b0, h: 1'b0, busy: 1'b1, done: 1'b0};
    localparam ctrl_t CW_DONE = '{m0: 2'd0, m1: 2'd0, m2: 2'd0, lx: 1'b0, ls: 1'b0,
                                  lh: 1'b0, h: 1'b0, busy: 1'b0, done: 1'b1};

endpackage

// File: rtl/bc_seq_if.sv
// Request and control-word bundle between a requester and the bc_seq controller.
interface bc_seq_if #(
    parameter int MSEL_W = 2,
    parameter int CNT_W  = 8
);
    logic              inicio;
    logic              abort;
    logic [CNT_W-1:0]  n_iter;
    logic [MSEL_W-1:0] M0;
    logic [MSEL_W-1:0] M1;
    logic [MSEL_W-1:0] M2;
    logic              LX;
    logic              LS;
    logic              LH;
    logic              H;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  iter_cnt;

    modport master (
        output inicio, abort, n_iter,
        input  M0, M1, M2, LX, LS, LH, H, busy, done, iter_cnt
    );

    modport slave (
        input  inicio, abort, n_iter,
        output M0, M1, M2, LX, LS, LH, H, busy, done, iter_cnt
    );
endinterface

// File: rtl/bc_iter_counter.sv
// Loop iteration counter: latches the requested count, counts completed passes
// and flags the final pass.
module bc_iter_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] n_in,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             zero
);
    logic [CNT_W-1:0] n_lat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_lat <= '0;
            cnt   <= '0;
        end else if (load) begin
            n_lat <= n_in;
            cnt   <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Compare one bit wider so the maximum count never aliases through a wrap.
    assign last = (({1'b0, cnt} + (CNT_W + 1)'(1)) == {1'b0, n_lat});
    assign zero = (n_lat == '0);
endmodule

// File: rtl/bc_seq.sv
// Moore sequencer stepping a datapath through INIT and a four-state loop
// repeated n_iter times, with abort and a one-cycle done pulse.
module bc_seq
    import bc_pkg::*;
#(
    parameter int MSEL_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    bc_seq_if.slave  bus
);
    if (MSEL_W < 2) begin : g_msel_check
        $error("bc_seq: MSEL_W must be at least 2");
    end

    state_t state;
    state_t next;
    logic   load;
    logic   inc;
    logic   last;
    logic   zero;
    ctrl_t  ctrl;

    bc_iter_counter #(.CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .inc     (inc),
        .n_in    (bus.n_iter),
        .cnt     (bus.iter_cnt),
        .last    (last),
        .zero    (zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    // Abort wins over every busy-state transition and leaves the counter untouched.
    always_comb begin
        next = state;
        load = 1'b0;
        inc  = 1'b0;
        if (bus.abort && state != IDLE && state != DONE) begin
            next = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.inicio) begin
                    next = INIT;
                    load = 1'b1;
                end
                INIT: next = zero ? DONE : S1;
                S1:   next = S2;
                S2:   next = S3;
                S3:   next = S4;
                S4: begin
                    inc  = 1'b1;
                    next = last ? DONE : S1;
                end
                DONE:    next = IDLE;
                default: next = IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl = CW_IDLE;
        case (state)
            IDLE:    ctrl = CW_IDLE;
            INIT:    ctrl = CW_INIT;
            S1:      ctrl = CW_S1;
            S2:      ctrl = CW_S2;
            S3:      ctrl = CW_S3;
            S4:      ctrl = CW_S4;
            DONE:    ctrl = CW_DONE;
            default: ctrl = CW_IDLE;
        endcase
    end

    assign bus.M0   = MSEL_W'(ctrl.m0);
    assign bus.M1   = MSEL_W'(ctrl.m1);
    assign bus.M2   = MSEL_W'(ctrl.m2);
    assign bus.LX   = ctrl.lx;
    assign bus.LS   = ctrl.ls;
    assign bus.LH   = ctrl.lh;
    assign bus.H    = ctrl.h;
    assign bus.busy = ctrl.busy;
    assign bus.done = ctrl.done;
endmodule

// File: tb/tb_bc_seq.sv
// Directed bench for bc_seq: a vector table for one full run plus hand-written
// sequences for zero count, held start, abort, async reset and a narrow instance.
module tb_bc_seq;
    // Expected words packed as {M0,M1,M2,LX,LS,LH,H,busy,done}.
    localparam logic [11:0] W_IDLE = 12'd0;
    localparam logic [11:0] W_INIT = {2'd0, 2'd1, 2'd0, 4'b1011, 2'b10};
    localparam logic [11:0] W_S1   = {2'd1, 2'd0, 2'd3, 4'b0101, 2'b10};
    localparam logic [11:0] W_S2   = {2'd2, 2'd0, 2'd0, 4'b0011, 2'b10};
    localparam logic [11:0] W_S3   = {2'd0, 2'd2, 2'd3, 4'b0100, 2'b10};
    localparam logic [11:0] W_S4   = {2'd3, 2'd0, 2'd2, 4'b0100, 2'b10};
    localparam logic [11:0] W_DONE = {2'd0, 2'd0, 2'd0, 4'b0000, 2'b01};

    typedef struct {
        string      name;
        logic       inicio;
        logic       abort;
        logic [7:0] n_iter;
        logic [11:0] exp_word;
        logic [7:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bc_seq_if #(.MSEL_W(2), .CNT_W(8)) bus ();
    bc_seq_if #(.MSEL_W(3), .CNT_W(4)) bus4 ();

    bc_seq #(.MSEL_W(2), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    bc_seq #(.MSEL_W(3), .CNT_W(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4.slave)
    );

    function automatic logic [11:0] word8();
        return {bus.M0, bus.M1, bus.M2, bus.LX, bus.LS, bus.LH, bus.H, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ini, input logic ab, input logic [7:0] n);
        bus.inicio = ini;
        bus.abort  = ab;
        bus.n_iter = n;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   done_cnt;
        int   done_at;
        logic [7:0] cnt_at_done;

        // Each row's inputs are sampled in the state left by the previous row.
        vecs[0] = '{"v_init",      1'b1, 1'b0, 8'd1, W_INIT, 8'd0};
        vecs[1] = '{"v_s1",        1'b0, 1'b0, 8'd9, W_S1,   8'd0};
        vecs[2] = '{"v_s2_ignore", 1'b1, 1'b0, 8'd9, W_S2,   8'd0};
        vecs[3] = '{"v_s3",        1'b0, 1'b0, 8'd9, W_S3,   8'd0};
        vecs[4] = '{"v_s4",        1'b0, 1'b0, 8'd9, W_S4,   8'd0};
        vecs[5] = '{"v_done",      1'b0, 1'b0, 8'd9, W_DONE, 8'd1};
        vecs[6] = '{"v_idle_ign",  1'b1, 1'b1, 8'd9, W_IDLE, 8'd1};
        vecs[7] = '{"v_idle_abort",1'b0, 1'b1, 8'd9, W_IDLE, 8'd1};

        applyStimulus(1'b0, 1'b0, 8'd0);
        bus4.inicio = 1'b0;
        bus4.abort  = 1'b0;
        bus4.n_iter = 4'd0;

        #3;
        checkOutput("reset_word", 32'(word8()), 32'(W_IDLE));
        checkOutput("reset_cnt", 32'(bus.iter_cnt), 0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        checkOutput("post_reset_idle", 32'(word8()), 32'(W_IDLE));

        // Full n_iter=1 run: accept at edge k, done seen after edge k+5 (cycle k+6).
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].inicio, vecs[i].abort, vecs[i].n_iter);
            tick();
            checkOutput({vecs[i].name, "_word"}, 32'(word8()), 32'(vecs[i].exp_word));
            checkOutput({vecs[i].name, "_cnt"}, 32'(bus.iter_cnt), 32'(vecs[i].exp_cnt));
        end

        // n_iter=0: INIT then straight to DONE, counter cleared on acceptance.
        applyStimulus(1'b1, 1'b0, 8'd0);
        tick();
        checkOutput("z_init", 32'(word8()), 32'(W_INIT));
        checkOutput("z_cnt_clear", 32'(bus.iter_cnt), 0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        tick();
        checkOutput("z_done", 32'(word8()), 32'(W_DONE));
        tick();
        checkOutput("z_idle", 32'(word8()), 32'(W_IDLE));
        checkOutput("z_cnt", 32'(bus.iter_cnt), 0);

        // n_iter=3 with inicio held: single done after edge k+13, restart right after.
        applyStimulus(1'b1, 1'b0, 8'd3);
        tick();
        checkOutput("h_init", 32'(word8()), 32'(W_INIT));
        done_cnt = 0;
        done_at = -1;
        cnt_at_done = '0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    cnt_at_done = bus.iter_cnt;
                end
            end
            if (i == 14) checkOutput("h_idle_gap", 32'(word8()), 32'(W_IDLE));
            if (i == 15) begin
                checkOutput("h_restart", 32'(word8()), 32'(W_INIT));
                checkOutput("h_restart_cnt", 32'(bus.iter_cnt), 0);
            end
        end
        checkOutput("h_done_edge", 32'(done_at), 13);
        checkOutput("h_done_count", 32'(done_cnt), 1);
        checkOutput("h_cnt_at_done", 32'(cnt_at_done), 3);
        applyStimulus(1'b0, 1'b1, 8'd3);
        tick();
        checkOutput("h_abort_init", 32'(word8()), 32'(W_IDLE));

        // n_iter=5, abort while in the second S3.
        applyStimulus(1'b1, 1'b0, 8'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd5);
        done_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        checkOutput("a_second_s3", 32'(word8()), 32'(W_S3));
        applyStimulus(1'b0, 1'b1, 8'd5);
        tick();
        checkOutput("a_idle", 32'(word8()), 32'(W_IDLE));
        checkOutput("a_cnt", 32'(bus.iter_cnt), 1);
        applyStimulus(1'b0, 1'b0, 8'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        checkOutput("a_no_done", 32'(done_cnt), 0);
        checkOutput("a_cnt_hold", 32'(bus.iter_cnt), 1);

        // Asynchronous reset in the second S2 with iter_cnt already at 1.
        applyStimulus(1'b1, 1'b0, 8'd4);
        tick();
        applyStimulus(1'b0, 1'b0, 8'd4);
        for (int i = 1; i <= 6; i++) tick();
        checkOutput("r_pre_s2", 32'(word8()), 32'(W_S2));
        checkOutput("r_pre_cnt", 32'(bus.iter_cnt), 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("r_async_word", 32'(word8()), 32'(W_IDLE));
        checkOutput("r_async_cnt", 32'(bus.iter_cnt), 0);
        tick();
        #2 reset_n = 1'b1;
        tick();
        checkOutput("r_idle_after", 32'(word8()), 32'(W_IDLE));
        applyStimulus(1'b1, 1'b0, 8'd2);
        tick();
        checkOutput("r_first_start", 32'(word8()), 32'(W_INIT));
        applyStimulus(1'b0, 1'b1, 8'd2);
        tick();
        checkOutput("r_abort_init", 32'(word8()), 32'(W_IDLE));
        applyStimulus(1'b0, 1'b0, 8'd2);

        // Narrow instance at its maximum count: done after edge k+61 (cycle k+62).
        bus4.n_iter = 4'd15;
        bus4.inicio = 1'b1;
        tick();
        bus4.inicio = 1'b0;
        bus4.n_iter = 4'd2;
        checkOutput("n_init_lx", 32'(bus4.LX), 1);
        done_cnt = 0;
        done_at = -1;
        cnt_at_done = '0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 1) checkOutput("n_s1_m2", 32'(bus4.M2), 32'(3'b011));
            if (i == 4) checkOutput("n_s4_m0", 32'(bus4.M0), 32'(3'b011));
            if (bus4.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    cnt_at_done = 8'(bus4.iter_cnt);
                end
            end
        end
        checkOutput("n_done_edge", 32'(done_at), 61);
        checkOutput("n_done_count", 32'(done_cnt), 1);
        checkOutput("n_cnt_at_done", 32'(cnt_at_done), 15);
        checkOutput("n_cnt_final", 32'(bus4.iter_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bc_seq.md
BC_SEQ -- requirements
Module: bc_seq

Interface
REQ-001 Parameter MSEL_W, default 2, width of each mux select output.
REQ-002 Parameter CNT_W, default 8, width of iteration count and counter.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port inicio  input  1  start request, sampled only in IDLE.
REQ-006 Port abort  input  1  cancel request, sampled in busy states.
REQ-007 Port n_iter  input  CNT_W  number of loop iterations, latched on start acceptance.
REQ-008 Ports M0, M1, M2  output  MSEL_W each  datapath mux selects.
REQ-009 Ports LX, LS, LH, H  output  1 each  datapath register load enables.
REQ-010 Port busy  output  1  high in INIT, S1, S2, S3 and S4.
REQ-011 Port done  output  1  single-cycle completion pulse.
REQ-012 Port iter_cnt  output  CNT_W  completed loop iterations in the current or last run.

Function
REQ-013 FSM states SHALL be IDLE, INIT, S1, S2, S3, S4 and DONE, with outputs a Moore decode of the registered state.
REQ-014 Control words SHALL be (unlisted signals 0): IDLE all 0; INIT M0=0 M1=1 M2=0 LX=1 LH=1 H=1; S1 M0=1 M2=3 LS=1 H=1; S2 M0=2 LH=1 H=1; S3 M1=2 M2=3 LS=1; S4 M0=3 M2=2 LS=1; DONE all 0 with done=1.
REQ-015 Select constants SHALL be zero-extended to MSEL_W, and MSEL_W below 2 SHALL be a parameter error.
REQ-016 IDLE with inicio=1 at an edge SHALL go to INIT, latch n_iter and clear iter_cnt to 0; otherwise the FSM SHALL stay in IDLE.
REQ-017 INIT SHALL go to S1 if latched n_iter is nonzero, else to DONE.
REQ-018 Transitions S1->S2->S3->S4 SHALL be unconditional.
REQ-019 On leaving S4, iter_cnt SHALL increment, and the FSM SHALL go to DONE if iter_cnt+1 equals latched n_iter, else to S1.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE, so done is a one-cycle pulse.
REQ-021 Latency SHALL be: inicio accepted at edge k gives done high in cycle k+2+4*n_iter (n_iter=0 gives done at k+2).
REQ-022 inicio while busy or in DONE SHALL be ignored, and n_iter changes after acceptance SHALL have no effect.
REQ-023 abort=1 in any busy state SHALL force IDLE at the next edge with no done pulse, leaving iter_cnt at its current value.
REQ-024 abort SHALL take priority over all other transitions, and abort in IDLE or DONE SHALL be ignored.
REQ-025 n_iter = 2^CNT_W-1 SHALL run to completion without iter_cnt wrapping.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, iter_cnt=0, the latched count to 0, and all outputs to 0, independent of clk.
REQ-027 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-028 After reset_n deasserts, the first edge SHALL behave as a normal IDLE cycle.

Structure
REQ-029 Package bc_pkg SHALL hold the state encoding and the per-state control-word constants.
REQ-030 The iteration counter with latch, clear, increment and terminal compare SHALL be sub-module bc_iter_counter, parameterised by CNT_W.
REQ-031 Output decode SHALL be a single case on state, with no extra output registers.

Verification
REQ-032 Reset then inicio pulse with n_iter=1 -> INIT, S1, S2, S3, S4, DONE, IDLE; per-cycle control words match REQ-014; done at k+6; iter_cnt=1.
REQ-033 n_iter=0 -> INIT then DONE; done at k+2; S1 never entered; iter_cnt=0.
REQ-034 n_iter=3 with inicio held high throughout -> done once at k+14, iter_cnt=3, and a new run starts at the first IDLE edge.
REQ-035 n_iter=5, abort in the second S3 -> IDLE next edge, no done, iter_cnt=1.
REQ-036 reset_n pulsed low asynchronously during S2 -> outputs 0 immediately, IDLE, iter_cnt=0, no done.
REQ-037 CNT_W=4, MSEL_W=3, n_iter=15 -> done at k+62, iter_cnt=15, M2 in S1 reads 3'b011.
